// File: rtl/hs_npu_mm_output_deskew.sv
// hs_npu_mm_output_deskew
//
// Purpose: realigns the diagonally skewed per-column result streams of the
// matrix-multiply unit into complete rows, requantizes each lane (round-half-up
// right shift, then saturate to OUT_WIDTH) and hands one row per valid/ready
// handshake to the writeback/activation path.
//
// Each column owns a DEPTH-entry circular buffer. A row is available once every
// lane holds at least one entry; loading the output register pops one entry from
// every lane in the same cycle, so rows leave strictly in arrival order.
//
// Ports:
//   clk        core clock
//   rst        asynchronous reset, active-high
//   flush      synchronous clear of all lanes, valid_o and overflow_o
//   data_i     SIZE x IN_WIDTH signed results, lane c at [c*IN_WIDTH +: IN_WIDTH]
//   valid_i    per-lane result valid (skewed by lane index)
//   shift_i    requantization right-shift amount, sampled when a row is loaded
//   row_o      SIZE x OUT_WIDTH requantized row, lane c at [c*OUT_WIDTH +: OUT_WIDTH]
//   valid_o    row_o holds a row
//   ready_i    downstream accepts row_o
//   overflow_o sticky: a result arrived at a full lane and was dropped
//
// Configuration macro: HS_NPU_OUT_RELU_EN -- when defined, negative lane results
// are forced to zero after saturation. Handshake timing is unaffected.

module hs_npu_mm_output_deskew #(
    parameter int SIZE      = 8,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [SIZE*IN_WIDTH-1:0]      data_i,
    input  logic [SIZE-1:0]               valid_i,
    input  logic [$clog2(IN_WIDTH)-1:0]   shift_i,
    output logic [SIZE*OUT_WIDTH-1:0]     row_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(IN_WIDTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    // Saturation bounds expressed in the IN_WIDTH+1 working width.
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [IN_WIDTH-1:0] mem    [SIZE][DEPTH];
    logic [AW-1:0]       wr_ptr [SIZE];
    logic [AW-1:0]       rd_ptr [SIZE];
    logic [AW:0]         count  [SIZE];

    logic [SIZE-1:0]          lane_nonempty;
    logic [SIZE-1:0]          wr_en;
    logic                     row_avail;
    logic                     load;
    logic                     ovf_hit;
    logic [SIZE*OUT_WIDTH-1:0] row_next;

    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [IN_WIDTH-1:0] x,
        input logic [SW-1:0]       s
    );
        logic signed [IN_WIDTH:0] xe;
        logic signed [IN_WIDTH:0] rnd;
        logic signed [IN_WIDTH:0] y;
        logic [OUT_WIDTH-1:0]     q;
        xe = {x[IN_WIDTH-1], x};
        if (s != '0) begin
            rnd = {{IN_WIDTH{1'b0}}, 1'b1} << (s - 1'b1);
            y   = (xe + rnd) >>> s;
        end else begin
            y = xe;
        end
        if (y > SAT_MAX)      q = SAT_MAX[OUT_WIDTH-1:0];
        else if (y < SAT_MIN) q = SAT_MIN[OUT_WIDTH-1:0];
        else                  q = y[OUT_WIDTH-1:0];
`ifdef HS_NPU_OUT_RELU_EN
        if (q[OUT_WIDTH-1]) q = '0;
`endif
        return q;
    endfunction

    always_comb begin
        lane_nonempty = '0;
        wr_en         = '0;
        row_next      = '0;
        for (int c = 0; c < SIZE; c++) begin
            lane_nonempty[c] = (count[c] != '0);
        end
        row_avail = &lane_nonempty;
        load      = row_avail && (!valid_o || ready_i);
        // A full lane still accepts a write when the same cycle pops it.
        for (int c = 0; c < SIZE; c++) begin
            wr_en[c] = valid_i[c] && ((count[c] != FULL) || load);
            row_next[c*OUT_WIDTH +: OUT_WIDTH] = requant(mem[c][rd_ptr[c]], shift_i);
        end
        ovf_hit = |(valid_i & ~wr_en);
    end

    // Storage carries no reset; pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < SIZE; c++) begin
            if (wr_en[c] && !flush) begin
                mem[c][wr_ptr[c]] <= data_i[c*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < SIZE; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            row_o      <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else if (flush) begin
            for (int c = 0; c < SIZE; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            for (int c = 0; c < SIZE; c++) begin
                if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (load)     rd_ptr[c] <= rd_ptr[c] + 1'b1;
                count[c] <= count[c] + {{AW{1'b0}}, wr_en[c]} - {{AW{1'b0}}, load};
            end
            if (load) begin
                row_o   <= row_next;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
            if (ovf_hit) overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_npu_mm_output_deskew.sv
module tb_hs_npu_mm_output_deskew;

    localparam int SIZE  = 4;
    localparam int IW    = 32;
    localparam int OW    = 16;
    localparam int DEPTH = 16;
    localparam int SW    = $clog2(IW);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [SIZE*IW-1:0]   data_i;
    logic [SIZE-1:0]      valid_i;
    logic [SW-1:0]        shift_i;
    logic [SIZE*OW-1:0]   row_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 overflow_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [SIZE*OW-1:0] sb[$];

    hs_npu_mm_output_deskew #(
        .SIZE(SIZE), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .data_i(data_i), .valid_i(valid_i),
        .shift_i(shift_i), .row_o(row_o), .valid_o(valid_o), .ready_i(ready_i),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [OW-1:0] model_q(input longint x, input int s);
        longint y;
        logic [63:0] yb;
        if (s > 0) y = (x + (longint'(1) << (s - 1))) >>> s;
        else       y = x;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
`ifdef HS_NPU_OUT_RELU_EN
        if (y < 0) y = 0;
`endif
        yb = y;
        return yb[OW-1:0];
    endfunction

    function automatic logic [SIZE*OW-1:0] mrow(input int base, input int r, input int s);
        logic [SIZE*OW-1:0] v;
        v = '0;
        for (int c = 0; c < SIZE; c++) v[c*OW +: OW] = model_q(longint'(base + 100*c + r), s);
        return v;
    endfunction

    // Inputs are driven right after the falling edge; outputs are checked here,
    // before the rising edge that would consume them.
    task automatic tick();
        logic [SIZE*OW-1:0] e;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_row", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("row", 64'(row_o), 64'(e));
            end
        end else if (valid_o && !ready_i && sb.size() > 0) begin
            chk("hold", 64'(row_o), 64'(sb[0]));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Lane c receives base+100*c+r in cycle r+c; ready_i low for rlen cycles from rlo.
    task automatic stream(input int nrows, input int base, input int rlo, input int rlen,
                          input bit chk_lat);
        for (int t = 0; t < nrows + SIZE - 1; t++) begin
            valid_i = '0;
            ready_i = !(t >= rlo && t < rlo + rlen);
            for (int c = 0; c < SIZE; c++) begin
                if (t - c >= 0 && t - c < nrows) begin
                    valid_i[c] = 1'b1;
                    data_i[c*IW +: IW] = base + 100*c + (t - c);
                end
            end
            if (t < nrows) sb.push_back(mrow(base, t, int'(shift_i)));
            tick();
            if (chk_lat) chk("latency_valid", 64'(valid_o), 64'(t >= SIZE));
        end
        valid_i = '0;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        valid_i = '0;
        for (int i = 0; i < 64 && sb.size() > 0; i++) tick();
        tick();
        tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(valid_o), 64'd0);
    endtask

    initial begin
        logic [SIZE*OW-1:0] e;
        rst = 1'b1; flush = 1'b0; data_i = '0; valid_i = '0; shift_i = '0; ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_row", 64'(row_o), 64'd0);
        chk("reset_ovf", 64'(overflow_o), 64'd0);

        // Deskew with latency check
        stream(4, 0, -100, 0, 1'b1);
        drain();

        // Backpressure mid-stream
        stream(6, 1000, 3, 5, 1'b0);
        drain();

        // Requantize, all lanes in one cycle
        shift_i = 5'd1;
        data_i = {32'(-80000), 32'(80000), 32'(-7), 32'(7)};
        valid_i = '1;
        e = '0;
        e[0*OW +: OW] = model_q(7, 1);
        e[1*OW +: OW] = model_q(-7, 1);
        e[2*OW +: OW] = model_q(80000, 1);
        e[3*OW +: OW] = model_q(-80000, 1);
        sb.push_back(e);
        tick();
        valid_i = '0;
        drain();
        shift_i = 5'd4;
        stream(3, -50, -100, 0, 1'b0);
        drain();
        shift_i = '0;

        // Overflow: 17 results into lane 0 with ready low
        ready_i = 1'b0;
        for (int k = 0; k < 17; k++) begin
            valid_i = 4'b0001;
            data_i[0 +: IW] = 3000 + k;
            tick();
            if (k == 15) chk("ovf_not_yet", 64'(overflow_o), 64'd0);
            if (k == 16) chk("ovf_set", 64'(overflow_o), 64'd1);
        end
        for (int k = 0; k < 16; k++) begin
            valid_i = 4'b1110;
            for (int c = 1; c < SIZE; c++) data_i[c*IW +: IW] = 3000 + 100*c + k;
            sb.push_back(mrow(3000, k, 0));
            tick();
        end
        drain();
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Flush with a held row and partial rows buffered
        stream(2, 4000, 0, 100, 1'b0);
        ready_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            valid_i = 4'b0111;
            for (int c = 0; c < SIZE; c++) data_i[c*IW +: IW] = 4500 + 100*c + t;
            tick();
        end
        flush = 1'b1;
        valid_i = '1;
        tick();
        flush = 1'b0;
        valid_i = '0;
        sb.delete();
        chk("flush_valid", 64'(valid_o), 64'd0);
        chk("flush_ovf", 64'(overflow_o), 64'd0);
        stream(4, 2000, -100, 0, 1'b0);
        drain();

        // Asynchronous reset between edges
        stream(2, 5000, 0, 100, 1'b0);
        ready_i = 1'b0;
        valid_i = 4'b0011;
        data_i[0 +: IW] = 5900;
        data_i[IW +: IW] = 5901;
        tick();
        valid_i = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(valid_o), 64'd0);
        chk("async_rst_row", 64'(row_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 4'b1100;
            tick();
            chk("no_stale_row", 64'(valid_o), 64'd0);
        end
        valid_i = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stream(3, 6000, -100, 0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
